// File: rtl/clock_monitor_if.sv
// rtl/clock_monitor_if.sv - signal bundle between a measured source and the clock monitor
interface clock_monitor_if #(
  parameter int CNT_W = 28
);
  logic             sig_in;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             stalled;

  modport master (
    output sig_in,
    input  rise_pulse, fall_pulse, period, high_time, meas_valid, stalled
  );

  modport slave (
    input  sig_in,
    output rise_pulse, fall_pulse, period, high_time, meas_valid, stalled
  );
endinterface

// File: rtl/clock_monitor.sv
// rtl/clock_monitor.sv - measures period and high time of a slow async square wave, flags stalls
module clock_monitor #(
  parameter int CNT_W   = 28,
  parameter int TIMEOUT = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  clock_monitor_if.slave  mon
);

  typedef enum logic [1:0] {IDLE, ARMED, MEAS} state_e;

  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             stalled_q, stalled_d;
  state_e           state_q, state_d;
  logic             rise, fall;

  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      stalled_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      s1_q      <= mon.sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      stalled_q <= stalled_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    stalled_d = stalled_q;
    pcnt_d    = rise ? ONE_C : ((pcnt_q == TO_C) ? TO_C : pcnt_q + ONE_C);
    hcnt_d    = rise ? ONE_C : ((hcnt_q == TO_C) ? TO_C : hcnt_q + ONE_C);

    // A rising edge takes priority over a timeout landing in the same cycle
    if (rise) begin
      stalled_d = 1'b0;
      case (state_q)
        IDLE:    state_d = ARMED;
        ARMED: begin
          state_d  = MEAS;
          period_d = pcnt_q;
        end
        MEAS:    period_d = pcnt_q;
        default: state_d = IDLE;
      endcase
    end else if (pcnt_q == TO_C) begin
      stalled_d = 1'b1;
      state_d   = IDLE;
    end

    if (fall && (state_q != IDLE)) begin
      high_d = hcnt_q;
    end
  end

  assign mon.rise_pulse = rise;
  assign mon.fall_pulse = fall;
  assign mon.period     = period_q;
  assign mon.high_time  = high_q;
  assign mon.meas_valid = (state_q == MEAS);
  assign mon.stalled    = stalled_q;

endmodule

// File: tb/tb_clock_monitor.sv
// tb/tb_clock_monitor.sv - directed self-checking bench for clock_monitor
module tb_clock_monitor;
  localparam int W  = 8;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  clock_monitor_if #(.CNT_W(W)) bus ();

  clock_monitor #(.CNT_W(W), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  always #5 clk = ~clk;

  // Observation point is 1 time unit after each rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sig_in = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int rises = 0;
    rst = 1'b1;
    bus.sig_in = 1'b1;
    cyc();
    cyc();
    total++; if (bus.period !== 8'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", bus.period); end
    total++; if (bus.high_time !== 8'd0) begin bad++; $display("FAIL reset_high: got %0d want 0", bus.high_time); end
    total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL reset_mv: got %0b want 0", bus.meas_valid); end
    total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled: got %0b want 0", bus.stalled); end
    total++; if (bus.rise_pulse !== 1'b0) begin bad++; $display("FAIL reset_rise: got %0b want 0", bus.rise_pulse); end
    total++; if (bus.fall_pulse !== 1'b0) begin bad++; $display("FAIL reset_fall: got %0b want 0", bus.fall_pulse); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (bus.rise_pulse === 1'b1) rises++;
      if (i == 1) begin
        total++; if (bus.rise_pulse !== 1'b1) begin bad++; $display("FAIL release_rise_time: got %0b want 1", bus.rise_pulse); end
      end
    end
    total++; if (rises != 1) begin bad++; $display("FAIL release_rise_count: got %0d want 1", rises); end
    total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL release_mv: got %0b want 0", bus.meas_valid); end
  endtask

  task automatic test_single_step();
    do_reset();
    for (int i = 0; i < 3; i++) cyc();
    for (int i = 0; i < 6; i++) begin
      bus.sig_in = 1'b1;
      cyc();
      total++; if (bus.rise_pulse !== (i == 1)) begin bad++; $display("FAIL step_rise[%0d]: got %0b want %0b", i, bus.rise_pulse, (i == 1)); end
      total++; if (bus.fall_pulse !== 1'b0) begin bad++; $display("FAIL step_fall[%0d]: got %0b want 0", i, bus.fall_pulse); end
    end
  endtask

  task automatic test_periodic();
    int rises = 0;
    int first_rise = -1;
    int first_mv = -1;
    int last = -1;
    int gap_err = 0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      bus.sig_in = ((i % 10) < 4);
      cyc();
      if (bus.rise_pulse === 1'b1) begin
        rises++;
        if (first_rise < 0) first_rise = i;
        else if (i - last != 10) gap_err++;
        last = i;
      end
      if (bus.meas_valid === 1'b1 && first_mv < 0) first_mv = i;
    end
    total++; if (rises != 5) begin bad++; $display("FAIL per_rises: got %0d want 5", rises); end
    total++; if (first_rise != 1) begin bad++; $display("FAIL per_first_rise: got %0d want 1", first_rise); end
    total++; if (gap_err != 0) begin bad++; $display("FAIL per_gap: got %0d want 0", gap_err); end
    total++; if (first_mv != 12) begin bad++; $display("FAIL per_first_mv: got %0d want 12", first_mv); end
    total++; if (bus.period !== 8'd10) begin bad++; $display("FAIL per_period: got %0d want 10", bus.period); end
    total++; if (bus.high_time !== 8'd4) begin bad++; $display("FAIL per_high: got %0d want 4", bus.high_time); end
    total++; if (bus.meas_valid !== 1'b1) begin bad++; $display("FAIL per_mv: got %0b want 1", bus.meas_valid); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 141; i++) begin
      bus.sig_in = (i < 30) ? ((i % 10) < 4) : ((i >= 130) && (i < 134));
      cyc();
      if (i == 121) begin
        total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL stall_early: got %0b want 0", bus.stalled); end
        total++; if (bus.meas_valid !== 1'b1) begin bad++; $display("FAIL stall_mv_early: got %0b want 1", bus.meas_valid); end
      end
      if (i == 122 || i == 129) begin
        total++; if (bus.stalled !== 1'b1) begin bad++; $display("FAIL stall_set[%0d]: got %0b want 1", i, bus.stalled); end
        total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL stall_mv[%0d]: got %0b want 0", i, bus.meas_valid); end
        total++; if (bus.period !== 8'd10) begin bad++; $display("FAIL stall_period[%0d]: got %0d want 10", i, bus.period); end
      end
      if (i == 132) begin
        total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL stall_clear: got %0b want 0", bus.stalled); end
        total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL stall_armed_mv: got %0b want 0", bus.meas_valid); end
      end
    end
  endtask

  task automatic test_edge_wins();
    do_reset();
    for (int i = 0; i < 104; i++) begin
      bus.sig_in = (i < 4) || (i >= 100);
      cyc();
      if (i == 101) begin
        total++; if (bus.rise_pulse !== 1'b1) begin bad++; $display("FAIL ew_rise: got %0b want 1", bus.rise_pulse); end
      end
      if (i == 101 || i == 102) begin
        total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL ew_stalled[%0d]: got %0b want 0", i, bus.stalled); end
      end
      if (i == 102) begin
        total++; if (bus.meas_valid !== 1'b1) begin bad++; $display("FAIL ew_mv: got %0b want 1", bus.meas_valid); end
        total++; if (bus.period !== 8'd100) begin bad++; $display("FAIL ew_period: got %0d want 100", bus.period); end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      bus.sig_in = ((i % 10) < 4);
      cyc();
    end
    total++; if (bus.period !== 8'd10) begin bad++; $display("FAIL rm_pre_period: got %0d want 10", bus.period); end
    rst = 1'b1;
    bus.sig_in = 1'b0;
    cyc();
    rst = 1'b0;
    total++; if (bus.period !== 8'd0) begin bad++; $display("FAIL rm_period: got %0d want 0", bus.period); end
    total++; if (bus.high_time !== 8'd0) begin bad++; $display("FAIL rm_high: got %0d want 0", bus.high_time); end
    total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL rm_mv: got %0b want 0", bus.meas_valid); end
    total++; if (bus.stalled !== 1'b0) begin bad++; $display("FAIL rm_stalled: got %0b want 0", bus.stalled); end
    for (int i = 0; i < 13; i++) begin
      bus.sig_in = ((i % 10) < 4);
      cyc();
      if (i == 11) begin
        total++; if (bus.meas_valid !== 1'b0) begin bad++; $display("FAIL rm_mv_pre: got %0b want 0", bus.meas_valid); end
      end
      if (i == 12) begin
        total++; if (bus.meas_valid !== 1'b1) begin bad++; $display("FAIL rm_mv_post: got %0b want 1", bus.meas_valid); end
        total++; if (bus.period !== 8'd10) begin bad++; $display("FAIL rm_period_post: got %0d want 10", bus.period); end
      end
    end
  endtask

  task automatic test_period_change();
    int mv_drops = 0;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      bus.sig_in = (i < 30) ? ((i % 10) < 4) : (((i - 30) % 16) < 8);
      cyc();
      if (i >= 12 && bus.meas_valid !== 1'b1) mv_drops++;
      if (i == 39) begin
        total++; if (bus.high_time !== 8'd4) begin bad++; $display("FAIL pc_high_old: got %0d want 4", bus.high_time); end
      end
      if (i == 40 || i == 56) begin
        total++; if (bus.high_time !== 8'd8) begin bad++; $display("FAIL pc_high_new[%0d]: got %0d want 8", i, bus.high_time); end
      end
      if (i == 47) begin
        total++; if (bus.period !== 8'd10) begin bad++; $display("FAIL pc_period_old: got %0d want 10", bus.period); end
      end
      if (i == 48) begin
        total++; if (bus.period !== 8'd16) begin bad++; $display("FAIL pc_period_new: got %0d want 16", bus.period); end
      end
    end
    total++; if (mv_drops != 0) begin bad++; $display("FAIL pc_mv_drops: got %0d want 0", mv_drops); end
  endtask

  initial begin
    bus.sig_in = 1'b0;
    test_reset();
    test_single_step();
    test_periodic();
    test_stall();
    test_edge_wins();
    test_reset_mid();
    test_period_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
